// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types, defaults and helpers for the FIFO write-side
//                arbiter and the cyclic priority selector.
//                  - arb_state_t : arbiter FSM encoding (IDLE, OWN)
//                  - idx_w()     : index width for an N-entry selection
//                  - N_REQ_DEF / MAX_BURST_DEF : default configuration
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 4;

  // Explicit 1-bit encoding so the state register width is fixed.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Width of an index able to address n entries; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational cyclic priority search. Returns the first set
//                bit of req at or after position ptr, wrapping from N_REQ-1
//                back to 0. Kept free of arbiter state so a read-side
//                scheduler can reuse it.
//  Ports       : req   in  N_REQ  request vector
//                ptr   in  IDX_W  search start position (must be < N_REQ)
//                found out 1      at least one request bit is set
//                idx   out IDX_W  index of the selected request
//  Revision    : 1.0  initial release
// ============================================================================
module rr_select
  import fifo_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Doubling the vector and shifting by ptr turns the cyclic search into a
  // plain lowest-set-bit search over the first N_REQ positions.
  logic [2*N_REQ-1:0] w_rot;

  always_comb begin : p_search
    int s;
    w_rot = {req, req} >> ptr;
    found = 1'b0;
    idx   = '0;
    s     = 0;
    // Walk from the farthest position down so the nearest hit wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        s = int'(ptr) + k;
        if (s >= N_REQ) begin
          s = s - N_REQ;
        end
        found = 1'b1;
        idx   = IDX_W'(s);
      end
    end
  end

endmodule : rr_select
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin write-port arbiter sharing one synchronous FIFO
//                among N_REQ producers. A grant lasts up to MAX_BURST words,
//                after which ownership rotates. Writes are suppressed while
//                the FIFO reports FULL, so it can never overflow.
//  Ports       : clk        in  1              rising-edge clock
//                rst        in  1              asynchronous active-high reset
//                req        in  N_REQ          per-producer valid
//                req_data   in  N_REQ*w_data   producer i at [i*w_data +: w_data]
//                ack        out N_REQ          one-hot, word taken this edge
//                FULL       in  1              FIFO full flag (current cycle)
//                wr         out 1              FIFO write strobe
//                WRITE_DATA out w_data         FIFO write data
//                owner      out IDX_W          current grantee index
//                busy       out 1              arbiter is in the OWN state
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int w_data    = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*w_data-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  input  logic                      FULL,
  output logic                      wr,
  output logic [w_data-1:0]         WRITE_DATA,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic                      busy
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_own;
  logic             w_owner_req;
  logic             w_wr;
  logic [IDX_W-1:0] w_owner_next;
  logic [CNT_W-1:0] w_burst_inc;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (w_found),
    .idx   (w_sel_idx)
  );

  assign w_own       = (state_q == ST_OWN);
  assign w_owner_req = req[owner_q];
  // FULL gates the strobe directly; a FULL drop lets the write through in
  // the same cycle.
  assign w_wr        = w_own & w_owner_req & ~FULL;

  assign w_owner_next = (owner_q == c_idx_last) ? '0 : owner_q + IDX_W'(1);
  assign w_burst_inc  = burst_cnt_q + CNT_W'(1);

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin : p_ack
    ack = '0;
    if (w_wr) begin
      ack[owner_q] = 1'b1;
    end
  end

  // Data is forced to zero when no write happens so the FIFO bus is quiet.
  always_comb begin : p_wdata
    WRITE_DATA = '0;
    if (w_wr) begin
      WRITE_DATA = req_data[int'(owner_q)*w_data +: w_data];
    end
  end

  assign wr    = w_wr;
  assign busy  = w_own;
  assign owner = owner_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin : p_next
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // One selection cycle; no write is issued here.
        if (w_found) begin
          owner_d     = w_sel_idx;
          burst_cnt_d = '0;
          state_d     = ST_OWN;
        end
      end

      ST_OWN: begin
        if (!w_owner_req) begin
          // Owner has nothing more to send: hand the port on.
          state_d  = ST_IDLE;
          rr_ptr_d = w_owner_next;
        end else if (w_wr) begin
          burst_cnt_d = w_burst_inc;
          if (w_burst_inc == c_burst_max) begin
            state_d  = ST_IDLE;
            rr_ptr_d = w_owner_next;
          end
        end
        // Owner requesting but FULL: stall, everything holds.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Two instances share
//                the stimulus: dut (MAX_BURST=4) and dut1 (MAX_BURST=1).
//                Producer i presents the word {i, cnt[i]} and advances cnt[i]
//                on each expected ack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        FULL;

  logic [3:0]  ack0, ack1;
  logic        wr0, wr1;
  logic [7:0]  wd0, wd1;
  logic [1:0]  own0, own1;
  logic        busy0, busy1;

  fifo_wr_arbiter #(.N_REQ(4), .w_data(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack0),
    .FULL(FULL), .wr(wr0), .WRITE_DATA(wd0), .owner(own0), .busy(busy0)
  );

  fifo_wr_arbiter #(.N_REQ(4), .w_data(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack1),
    .FULL(FULL), .wr(wr1), .WRITE_DATA(wd1), .owner(own1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         nchk;
  int         nerr;
  int         stepno;
  logic [5:0] cnt [4];
  bit         proto_on;

  // --------------------------------------------------------------------------
  // Producer protocol monitor (MAX_BURST=4 instance) and ack counter
  // --------------------------------------------------------------------------
  logic [3:0]  p_req;
  logic [3:0]  p_ack;
  logic [31:0] p_data;
  bit          p_valid = 1'b0;
  int          ackcnt [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    if (proto_on && !rst && p_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (p_req[i] && !p_ack[i]) begin
          assert (req[i] && (req_data[i*8 +: 8] == p_data[i*8 +: 8]))
            else $error("producer %0d protocol violation", i);
        end
      end
    end
    p_req   <= req;
    p_ack   <= ack0;
    p_data  <= req_data;
    p_valid <= 1'b1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (ack0[i]) ackcnt[i] <= ackcnt[i] + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, stepno, act, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = {2'(i), cnt[i]};
    end
  endtask

  // Entered just after a falling edge: drive, check, then cross one rising edge.
  task automatic step(input bit r, input logic [3:0] rq, input bit f,
                      input bit ewr, input bit ebusy, input int eown,
                      input bit u1);
    logic [3:0] a, eack;
    logic       w, b;
    logic [7:0] d, edat;
    logic [1:0] o;
    rst  = r;
    req  = rq;
    FULL = f;
    drive_data();
    #1;
    if (u1) begin
      a = ack1; w = wr1; d = wd1; o = own1; b = busy1;
    end else begin
      a = ack0; w = wr0; d = wd0; o = own0; b = busy0;
    end
    eack = ewr ? (4'b0001 << eown) : 4'b0000;
    edat = ewr ? {2'(eown), cnt[eown]} : 8'h00;
    chk("wr", int'(w), int'(ewr));
    chk("ack", int'(a), int'(eack));
    chk("WRITE_DATA", int'(d), int'(edat));
    chk("busy", int'(b), int'(ebusy));
    chk("owner", int'(o), eown);
    if (ewr) cnt[eown] = cnt[eown] + 6'd1;
    stepno++;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed table: single producer, wrap-around, FULL stall, re-grant
  // --------------------------------------------------------------------------
  typedef struct {
    bit         r;
    logic [3:0] rq;
    bit         f;
    bit         ewr;
    bit         ebusy;
    int         eown;
    int         err;   // expected rr_ptr after the edge, -1 = not checked
  } vec_t;

  vec_t tab [29];

  int s0, s1, a0, a1, prev, own, len;

  initial begin
    nchk = 0; nerr = 0; stepno = 0;
    rst = 1'b1; req = 4'b0000; FULL = 1'b0; proto_on = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 6'd0;
    drive_data();

    tab[0]  = '{1, 4'b0000, 0, 0, 0, 0, 0};
    tab[1]  = '{0, 4'b0100, 0, 0, 0, 0, -1};
    tab[2]  = '{0, 4'b0100, 0, 1, 1, 2, -1};
    tab[3]  = '{0, 4'b0100, 0, 1, 1, 2, -1};
    tab[4]  = '{0, 4'b0100, 0, 1, 1, 2, -1};
    tab[5]  = '{0, 4'b0000, 0, 0, 1, 2, 3};
    tab[6]  = '{0, 4'b1000, 0, 0, 0, 2, -1};
    tab[7]  = '{0, 4'b1000, 0, 1, 1, 3, -1};
    tab[8]  = '{0, 4'b0000, 0, 0, 1, 3, 0};
    tab[9]  = '{0, 4'b1001, 0, 0, 0, 3, -1};
    tab[10] = '{0, 4'b1001, 0, 1, 1, 0, -1};
    tab[11] = '{0, 4'b1000, 0, 0, 1, 0, 1};
    tab[12] = '{0, 4'b1000, 0, 0, 0, 0, -1};
    tab[13] = '{0, 4'b1000, 0, 1, 1, 3, -1};
    tab[14] = '{0, 4'b0000, 0, 0, 1, 3, 0};
    tab[15] = '{0, 4'b0000, 0, 0, 0, 3, -1};
    tab[16] = '{0, 4'b0010, 0, 0, 0, 3, -1};
    tab[17] = '{0, 4'b0010, 0, 1, 1, 1, -1};
    tab[18] = '{0, 4'b0010, 1, 0, 1, 1, -1};
    tab[19] = '{0, 4'b0010, 1, 0, 1, 1, -1};
    tab[20] = '{0, 4'b0010, 1, 0, 1, 1, -1};
    tab[21] = '{0, 4'b0010, 1, 0, 1, 1, -1};
    tab[22] = '{0, 4'b0010, 1, 0, 1, 1, -1};
    tab[23] = '{0, 4'b0010, 0, 1, 1, 1, -1};
    tab[24] = '{0, 4'b0010, 0, 1, 1, 1, -1};
    tab[25] = '{0, 4'b0010, 0, 1, 1, 1, 2};
    tab[26] = '{0, 4'b0010, 0, 0, 0, 1, -1};
    tab[27] = '{0, 4'b0010, 0, 1, 1, 1, -1};
    tab[28] = '{0, 4'b0000, 0, 0, 1, 1, 2};

    @(negedge clk);
    for (int k = 0; k < 29; k++) begin
      step(tab[k].r, tab[k].rq, tab[k].f, tab[k].ewr, tab[k].ebusy,
           tab[k].eown, 1'b0);
      if (tab[k].err >= 0) chk("rr_ptr", int'(dut.rr_ptr_q), tab[k].err);
    end

    // ------------------------------------------------------------------
    // Reset mid-burst: second word of producer 2 is never acked, and the
    // search restarts from index 0 (selects 1, not 2).
    // ------------------------------------------------------------------
    step(0, 4'b0110, 0, 0, 0, 1, 0);
    step(0, 4'b0110, 0, 1, 1, 2, 0);
    step(1, 4'b0110, 0, 0, 0, 0, 0);
    chk("rr_ptr_after_reset", int'(dut.rr_ptr_q), 0);
    step(0, 4'b0110, 0, 0, 0, 0, 0);
    step(0, 4'b0110, 0, 1, 1, 1, 0);
    step(0, 4'b0100, 0, 0, 1, 1, 0);
    step(0, 4'b0100, 0, 0, 0, 1, 0);
    step(0, 4'b0100, 0, 1, 1, 2, 0);  // same un-acked word resent
    step(0, 4'b0000, 0, 0, 1, 2, 0);

    // ------------------------------------------------------------------
    // Contention: producers 0 and 1, 10 words each, bursts of 4.
    // ------------------------------------------------------------------
    step(1, 4'b0000, 0, 0, 0, 0, 0);
    s0 = 0; s1 = 0; prev = 0;
    a0 = ackcnt[0]; a1 = ackcnt[1];
    for (int b = 0; b < 6; b++) begin
      own = b % 2;
      len = (b < 4) ? 4 : 2;
      step(0, {2'b00, (s1 < 10), (s0 < 10)}, 0, 0, 0, prev, 0);
      for (int n = 0; n < len; n++) begin
        step(0, {2'b00, (s1 < 10), (s0 < 10)}, 0, 1, 1, own, 0);
        if (own == 0) s0++; else s1++;
      end
      if (len < 4) step(0, {2'b00, (s1 < 10), (s0 < 10)}, 0, 0, 1, own, 0);
      prev = own;
    end
    chk("words_p0", ackcnt[0] - a0, 10);
    chk("words_p1", ackcnt[1] - a1, 10);

    // ------------------------------------------------------------------
    // Burst cap of 1 on dut1: strict rotation with one bubble per word.
    // ------------------------------------------------------------------
    proto_on = 1'b0;
    step(1, 4'b0000, 0, 0, 0, 0, 1);
    step(0, 4'b1111, 0, 0, 0, 0, 1);
    for (int p = 0; p < 5; p++) begin
      step(0, 4'b1111, 0, 1, 1, p % 4, 1);
      if (p < 4) step(0, 4'b1111, 0, 0, 0, p % 4, 1);
    end

    req = 4'b0000;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
